// File: rtl/fetch_pkg.sv
// fetch_pkg: immediate-format codes, RV32 opcodes, NOP and the opcode predecoder shared by the core front end.
package fetch_pkg;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } fetch_entry_t;

    // Loads, OP-IMM, JALR, SYSTEM and every unknown opcode fall through to the I format.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        return op == OP_STORE ? IMM_S :
               op == OP_BRANCH ? IMM_B :
               (op == OP_LUI || op == OP_AUIPC) ? IMM_U :
               op == OP_JAL ? IMM_J : IMM_I;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO with flush; head data comes straight from storage registers.
module fetch_queue #(
    parameter int            DEPTH   = 2,
    parameter int            W       = 64,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd, wr;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign dout = mem[rd];

    // Storage and pointers; flush empties the queue but leaves stale data behind an invalid head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) mem[wr] <= din;
            wr <= push ? nxt(wr) : wr;
            rd <= pop ? nxt(rd) : rd;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the imem req/gnt/rvalid port, queues instructions and predecodes Imm_src.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect raises sticky Misalign_err and halts issue.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        Id_ready,
    output logic        Ins_valid,
    output logic [31:0] Ins,
    output logic [31:0] Ins_pc,
    output logic [2:0]  Imm_src,
    output logic        Misalign_err
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   pc, rsp_pc, rpc;
    logic [CW-1:0] count, osd, drop, osd_nxt;
    logic          run, mis, grant, pop, push;
    fetch_entry_t  head, din;

    assign grant = imem_req && imem_gnt;
    assign pop = Ins_valid && Id_ready;
    assign push = imem_rvalid && drop == '0 && !redirect;
    assign osd_nxt = osd + CW'(grant) - CW'(imem_rvalid);
    assign Ins_valid = count != '0;
    // The slot freed by this cycle's pop is counted as available, which keeps one instruction per cycle flowing
    assign imem_req = run && !mis && (int'(count) + int'(osd) - int'(pop) < BUF_DEPTH);
    assign imem_addr = pc;
    assign din = '{ins: imem_rdata, pc: rsp_pc};
    assign Ins = head.ins;
    assign Ins_pc = head.pc;
    assign Imm_src = imm_sel(head.ins[6:0]);
    assign Misalign_err = mis;

`ifdef FETCH_MISALIGN_CHK_EN
    assign rpc = redirect_pc;
    // Sticky misalignment flag, rewritten by every redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis <= 1'b0;
        else if (redirect) mis <= rpc[1:0] != 2'b00;
    end
`else
    assign rpc = redirect_pc & 32'hFFFF_FFFC;
    assign mis = 1'b0;
`endif

    // Issue PC, response tag PC and in-flight bookkeeping; a redirect discards everything still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            osd <= '0;
            drop <= '0;
        end else begin
            run <= 1'b1;
            osd <= osd_nxt;
            pc <= redirect ? rpc : grant ? pc + 32'd4 : pc;
            rsp_pc <= redirect ? rpc : push ? rsp_pc + 32'd4 : rsp_pc;
            drop <= redirect ? osd_nxt : (imem_rvalid && drop != '0) ? drop - CW'(1) : drop;
        end
    end

    fetch_queue #(
        .DEPTH  (BUF_DEPTH),
        .W      ($bits(fetch_entry_t)),
        .RST_VAL({NOP, 32'h0})
    ) u_queue (
        .clk  (clk),
        .rst  (rst),
        .flush(redirect),
        .push (push),
        .pop  (pop),
        .din  (din),
        .dout (head),
        .count(count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: epoch-tagged transaction model of fetch_stage driven by a randomised in-order memory.
module tb_fetch_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect = 1'b0, Id_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        Ins_valid, Misalign_err;
    logic [31:0] Ins, Ins_pc;
    logic [2:0]  Imm_src;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .Id_ready(Id_ready),
        .Ins_valid(Ins_valid), .Ins(Ins), .Ins_pc(Ins_pc), .Imm_src(Imm_src),
        .Misalign_err(Misalign_err)
    );

    typedef struct {logic [31:0] ins; logic [2:0] imm;} vec_t;
    typedef struct {logic [31:0] addr; int ep; int cyc;} rq_t;

    vec_t        vec [7];
    rq_t         respq [$];
    logic [31:0] bufq [$];
    logic [31:0] issue_pc = '0;
    int          epoch = 0, cyc = 0, total = 0, bad = 0, ready_mode = 0;
    bit          run_m = 0, mis_m = 0, prev_redir = 0, fast = 1, resp_en = 1, rd_req = 0;
    logic [31:0] rd_pc = '0;
    logic        last_valid = 0, last_req = 0, last_g = 0, last_pop = 0, last_mis = 0;
    logic [31:0] last_ins = '0, last_ins_pc = '0;
    logic [2:0]  last_imm = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        int idx;
        if (a >= 32'h400 && a < 32'h41C) begin
            idx = int'((a - 32'h400) >> 2);
            return vec[idx].ins;
        end
        case (a[4:2])
            3'd0: op = 7'h03;
            3'd1: op = 7'h13;
            3'd2: op = 7'h23;
            3'd3: op = 7'h63;
            3'd4: op = 7'h37;
            3'd5: op = 7'h6F;
            3'd6: op = 7'h67;
            default: op = 7'h33;
        endcase
        return {a[26:2], op};
    endfunction

    function automatic logic [2:0] ref_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_gnt = 0;
        imem_rvalid = 0;
        redirect = 0;
        Id_ready = 0;
        respq.delete();
        bufq.delete();
        issue_pc = 32'h0;
        run_m = 0;
        mis_m = 0;
        prev_redir = 0;
        last_g = 0;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(Ins_valid), 0);
        chk("rst_ins", Ins, 32'h0000_0013);
        chk("rst_ins_pc", Ins_pc, 0);
        chk("rst_imm", 32'(Imm_src), 0);
        chk("rst_mis", 32'(Misalign_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cycle();
        bit g, rv, pop, rd;
        logic [31:0] ga, rp;
        rq_t r;
        @(negedge clk);
        rd = rd_req;
        rp = rd_pc;
        rd_req = 0;
        redirect = rd;
        redirect_pc = rd ? rp : $urandom;
        Id_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : ($urandom_range(0, 1) != 0);
        rv = resp_en && respq.size() > 0 && (fast || $urandom_range(0, 2) != 0);
        if (rv) rv = respq[0].cyc < cyc;
        imem_rvalid = rv;
        imem_rdata = $urandom;
        if (rv) imem_rdata = mem_word(respq[0].addr);
        #1;
        imem_gnt = imem_req && (fast || $urandom_range(0, 3) != 0);
        #1;
        pop = bufq.size() != 0 && Id_ready;
        if (prev_redir) chk("valid_after_redirect", 32'(Ins_valid), 0);
        chk("ins_valid", 32'(Ins_valid), 32'(bufq.size() != 0));
        chk("imem_req", 32'(imem_req),
            32'(run_m && !mis_m && (bufq.size() + respq.size() - int'(pop) < DEPTH)));
        g = imem_req && imem_gnt;
        ga = imem_addr;
        if (g) chk("imem_addr", imem_addr, issue_pc);
        if (bufq.size() != 0) begin
            chk("ins_pc", Ins_pc, bufq[0]);
            chk("ins", Ins, mem_word(bufq[0]));
            chk("imm_src", 32'(Imm_src), 32'(ref_imm(mem_word(bufq[0]))));
        end
        chk("misalign", 32'(Misalign_err), 32'(mis_m));
        last_valid = Ins_valid;
        last_ins = Ins;
        last_ins_pc = Ins_pc;
        last_imm = Imm_src;
        last_req = imem_req;
        last_g = g;
        last_pop = Ins_valid && Id_ready;
        last_mis = Misalign_err;
        @(posedge clk);
        run_m = 1;
        if (g) begin
            respq.push_back('{ga, epoch, cyc});
            issue_pc += 4;
        end
        if (rv) r = respq.pop_front();
        if (pop) void'(bufq.pop_front());
        if (rv && r.ep == epoch) bufq.push_back(r.addr);
        if (rd) begin
            bufq.delete();
            epoch++;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_m = rp[1:0] != 2'b00;
            issue_pc = rp;
`else
            issue_pc = {rp[31:2], 2'b00};
`endif
        end
        prev_redir = rd;
        cyc++;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] exp);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!last_valid && n < 30);
        if (last_valid) chk(nm, last_ins_pc, exp);
        else chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n, k;
        logic [31:0] held, prev;
        vec[0] = '{32'h00C000EF, 3'd4};
        vec[1] = '{32'hFE208EE3, 3'd2};
        vec[2] = '{32'h00112623, 3'd1};
        vec[3] = '{32'h000012B7, 3'd3};
        vec[4] = '{32'h00000013, 3'd0};
        vec[5] = '{32'h00000017, 3'd3};
        vec[6] = '{32'h00000033, 3'd0};
        do_reset();

        n = 0;
        while (!last_g && n < 10) begin
            cycle();
            n++;
        end
        if (!last_g) chk("first_grant_timeout", 0, 1);
        cycle();
        chk("valid_grant_plus1", 32'(last_valid), 0);
        cycle();
        chk("valid_grant_plus2", 32'(last_valid), 1);
        chk("pc_grant_plus2", last_ins_pc, 0);
        n = 0;
        repeat (10) begin
            cycle();
            n += int'(last_pop);
        end
        chk("throughput", n, 10);

        ready_mode = 1;
        cycle();
        held = last_ins_pc;
        repeat (4) cycle();
        chk("stall_req", 32'(last_req), 0);
        chk("stall_valid", 32'(last_valid), 1);
        chk("stall_hold_pc", last_ins_pc, held);
        chk("stall_hold_ins", last_ins, mem_word(held));
        ready_mode = 0;
        prev = held;
        repeat (6) begin
            cycle();
            if (last_pop) begin
                chk("drain_order", last_ins_pc, prev);
                prev += 4;
            end
        end

        resp_en = 0;
        n = 0;
        while (respq.size() < 2 && n < 10) begin
            cycle();
            n++;
        end
        if (respq.size() < 2) chk("outstanding_timeout", 0, 1);
        rd_req = 1;
        rd_pc = 32'h100;
        resp_en = 1;
        cycle();
        wait_valid("redirect_outstanding_pc", 32'h100);

        repeat (5) cycle();
        rd_req = 1;
        rd_pc = 32'h200;
        cycle();
        chk("redirect_with_grant", 32'(last_g), 1);
        wait_valid("redirect_coincide_pc", 32'h200);

        rd_req = 1;
        rd_pc = 32'h400;
        cycle();
        k = 0;
        n = 0;
        while (k < 7 && n < 50) begin
            cycle();
            n++;
            if (last_valid) begin
                chk("vec_ins", last_ins, vec[k].ins);
                chk("vec_imm", 32'(last_imm), 32'(vec[k].imm));
                k++;
            end
        end
        if (k < 7) chk("vec_timeout", 0, 1);

        rd_req = 1;
        rd_pc = 32'h102;
        cycle();
`ifdef FETCH_MISALIGN_CHK_EN
        repeat (3) cycle();
        chk("misalign_set", 32'(last_mis), 1);
        chk("misalign_no_req", 32'(last_req), 0);
        rd_req = 1;
        rd_pc = 32'h104;
        cycle();
        wait_valid("misalign_clear_pc", 32'h104);
        chk("misalign_cleared", 32'(last_mis), 0);
`else
        wait_valid("forced_align_pc", 32'h100);
        chk("misalign_tied", 32'(last_mis), 0);
`endif

        ready_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) fast = $urandom_range(0, 1) != 0;
            if (i == 1500) do_reset();
            if ($urandom_range(0, 39) == 0) begin
                rd_req = 1;
                rd_pc = ($urandom & 32'h0000_0FFC) | ($urandom_range(0, 7) == 0 ? 32'd2 : 32'd0);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
